// File: rtl/iir_pkg.sv
`default_nettype none
// ============================================================================
// Module      : iir_pkg
// Description : Shared constants and FSM state type for the IIR MAC sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package iir_pkg;

   localparam int NB_DEF    = 3;
   localparam int NA_DEF    = 2;
   localparam int DW_DEF    = 8;
   localparam int FRAC_DEF  = 6;
   localparam int ACC_W_DEF = 20;

   // Coefficient bank map: b_k at B0_ADDR+k, a_j at A1_ADDR+j-1
   localparam logic [2:0] B0_ADDR = 3'd0;
   localparam logic [2:0] A1_ADDR = 3'(NB_DEF);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MAC  = 2'd1,
      ST_OUT  = 2'd2
   } state_e;

endpackage
`default_nettype wire

// File: rtl/iir_mac_unit.sv
`default_nettype none
// ============================================================================
// Module      : iir_mac_unit
// Description : Shared signed DW x DW multiplier with ACC_W accumulator and
//               output shift stage. IIR_SAT_EN selects clamping over wrap.
// Revision    : 1.0 - initial release
// ============================================================================
module iir_mac_unit
   import iir_pkg::*;
#(
   parameter int DW    = DW_DEF,
   parameter int FRAC  = FRAC_DEF,
   parameter int ACC_W = ACC_W_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic          en,
   input  logic [DW-1:0] coef,
   input  logic [DW-1:0] operand,
   output logic [DW-1:0] result
);

   logic signed [ACC_W-1:0]  acc_q;
   logic signed [ACC_W-1:0]  acc_d;
   logic signed [2*DW-1:0]   prod_w;

   always_comb begin
      prod_w = $signed(coef) * $signed(operand);
      acc_d  = acc_q;
      if (clr) begin
         acc_d = '0;
      end else if (en) begin
         acc_d = acc_q + ACC_W'(prod_w);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_d;
      end
   end

`ifdef IIR_SAT_EN
   localparam logic signed [ACC_W-1:0] MAX_V = ACC_W'((2 ** (DW - 1)) - 1);
   localparam logic signed [ACC_W-1:0] MIN_V = ACC_W'(-(2 ** (DW - 1)));

   logic signed [ACC_W-1:0] shifted_w;

   always_comb begin
      shifted_w = acc_q >>> FRAC;
      if (shifted_w > MAX_V) begin
         result = DW'(MAX_V);
      end else if (shifted_w < MIN_V) begin
         result = DW'(MIN_V);
      end else begin
         result = DW'(shifted_w);
      end
   end
`else
   assign result = DW'(acc_q >>> FRAC);
`endif

endmodule
`default_nettype wire

// File: rtl/iir_mac_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : iir_mac_sequencer
// Description : Direct-form-I IIR filter sequencing NB+NA taps per sample over
//               one shared MAC. Output clamping when IIR_SAT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module iir_mac_sequencer
   import iir_pkg::*;
#(
   parameter int NB    = NB_DEF,
   parameter int NA    = NA_DEF,
   parameter int DW    = DW_DEF,
   parameter int FRAC  = FRAC_DEF,
   parameter int ACC_W = ACC_W_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] din,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] dout,
   input  logic          cfg_we,
   input  logic [2:0]    cfg_addr,
   input  logic [DW-1:0] cfg_data,
   output logic          cfg_busy
);

   localparam int TAPS  = NB + NA;
   localparam int TAP_W = (TAPS > 1) ? $clog2(TAPS) : 1;

   state_e            state_q, state_d;
   logic [TAP_W-1:0]  tap_q, tap_d;
   logic [DW-1:0]     coef_q [TAPS];
   logic [DW-1:0]     coef_d [TAPS];
   logic [DW-1:0]     x_q    [NB];
   logic [DW-1:0]     x_d    [NB];
   logic [DW-1:0]     y_q    [NA];
   logic [DW-1:0]     y_d    [NA];
   logic [DW-1:0]     dhold_q, dhold_d;

   logic [DW-1:0]     coef_sel_w;
   logic [DW-1:0]     op_sel_w;
   logic [DW-1:0]     res_w;
   logic              hs_w;
   logic              last_w;
   logic              consume_w;

   assign hs_w      = (state_q == ST_IDLE) && in_valid;
   assign last_w    = (tap_q == TAP_W'(TAPS - 1));
   assign consume_w = (state_q == ST_OUT) && out_ready;

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (in_valid) state_d = ST_MAC;
         ST_MAC:  if (last_w)   state_d = ST_OUT;
         ST_OUT:  if (out_ready) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      in_ready  = rst && (state_q == ST_IDLE);
      cfg_busy  = rst && (state_q != ST_IDLE);
      out_valid = rst && (state_q == ST_OUT);
      if (!rst) begin
         dout = '0;
      end else if (state_q == ST_OUT) begin
         dout = res_w;
      end else begin
         dout = dhold_q;
      end
   end

   // Tap select: operand index k<NB reads x[n-k], beyond that y[n-(k-NB+1)]
   always_comb begin
      coef_sel_w = '0;
      op_sel_w   = '0;
      for (int k = 0; k < TAPS; k++) begin
         if (tap_q == TAP_W'(k)) coef_sel_w = coef_q[k];
      end
      for (int k = 0; k < NB; k++) begin
         if (tap_q == TAP_W'(k)) op_sel_w = x_q[k];
      end
      for (int j = 0; j < NA; j++) begin
         if (tap_q == TAP_W'(NB + j)) op_sel_w = y_q[j];
      end
   end

   always_comb begin
      tap_d   = tap_q;
      coef_d  = coef_q;
      x_d     = x_q;
      y_d     = y_q;
      dhold_d = dhold_q;
      if (hs_w) begin
         tap_d = '0;
      end else if (state_q == ST_MAC) begin
         tap_d = tap_q + 1'b1;
      end
      if ((state_q == ST_IDLE) && cfg_we) begin
         for (int k = 0; k < TAPS; k++) begin
            if (cfg_addr == 3'(k)) coef_d[k] = cfg_data;
         end
      end
      if (hs_w) begin
         x_d[0] = din;
      end
      if (consume_w) begin
         for (int k = 1; k < NB; k++) x_d[k] = x_q[k-1];
         y_d[0] = res_w;
         for (int j = 1; j < NA; j++) y_d[j] = y_q[j-1];
         dhold_d = res_w;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         tap_q   <= '0;
         dhold_q <= '0;
         for (int k = 0; k < TAPS; k++) coef_q[k] <= '0;
         for (int k = 0; k < NB; k++)   x_q[k]    <= '0;
         for (int j = 0; j < NA; j++)   y_q[j]    <= '0;
      end else begin
         tap_q   <= tap_d;
         dhold_q <= dhold_d;
         coef_q  <= coef_d;
         x_q     <= x_d;
         y_q     <= y_d;
      end
   end

   iir_mac_unit #(
      .DW    (DW),
      .FRAC  (FRAC),
      .ACC_W (ACC_W)
   ) u_mac (
      .clk     (clk),
      .rst     (rst),
      .clr     (hs_w),
      .en      (state_q == ST_MAC),
      .coef    (coef_sel_w),
      .operand (op_sel_w),
      .result  (res_w)
   );

endmodule
`default_nettype wire

// File: tb/tb_iir_mac_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_iir_mac_sequencer
// Description : Self-checking bench: directed vector table, corner sequences
//               and randomized samples against an arithmetic IIR model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_iir_mac_sequencer;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [7:0] din = '0;
   logic       out_valid;
   logic       out_ready = 1'b1;
   logic [7:0] dout;
   logic       cfg_we = 1'b0;
   logic [2:0] cfg_addr = '0;
   logic [7:0] cfg_data = '0;
   logic       cfg_busy;

   int errors = 0;
   int checks = 0;

   iir_mac_sequencer dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .din       (din),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .dout      (dout),
      .cfg_we    (cfg_we),
      .cfg_addr  (cfg_addr),
      .cfg_data  (cfg_data),
      .cfg_busy  (cfg_busy)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // ---------------- reference model: y = floor(sum(b*x) + sum(a*y)) / 64 ----------------
   int mb [5];
   int mx [3];
   int my [2];

   function automatic void model_reset();
      for (int i = 0; i < 5; i++) mb[i] = 0;
      for (int i = 0; i < 3; i++) mx[i] = 0;
      for (int i = 0; i < 2; i++) my[i] = 0;
   endfunction

   function automatic void model_write(int addr, int data);
      if (addr >= 0 && addr < 5) mb[addr] = data;
   endfunction

   function automatic int model_step(int x);
      int s;
      int y;
      for (int k = 2; k > 0; k--) mx[k] = mx[k-1];
      mx[0] = x;
      s = 0;
      for (int k = 0; k < 3; k++) s += mb[k] * mx[k];
      for (int j = 0; j < 2; j++) s += mb[3+j] * my[j];
      y = s >>> 6;
`ifdef IIR_SAT_EN
      if (y > 127)  y = 127;
      if (y < -128) y = -128;
`else
      y = ((y + 128) & 255) - 128;
`endif
      my[1] = my[0];
      my[0] = y;
      return y;
   endfunction

   // ---------------- helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string nm, input logic signed [31:0] act,
                        input logic signed [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   task automatic do_reset();
      rst = 1'b0;
      tick();
      tick();
      check("rst_in_ready", in_ready, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_dout", $signed(dout), 0);
      check("rst_cfg_busy", cfg_busy, 0);
      rst = 1'b1;
      tick();
      check("post_rst_in_ready", in_ready, 1);
      model_reset();
   endtask

   task automatic wcoef(input int addr, input int data);
      cfg_we   = 1'b1;
      cfg_addr = 3'(addr);
      cfg_data = 8'(data);
      tick();
      cfg_we   = 1'b0;
      model_write(addr, data);
   endtask

   // One sample through the DUT; optional stall in OUT with cfg pokes (must be dropped)
   task automatic run_sample(input int x, input int stall, input bit poke,
                             output int y, output int lat);
      logic [7:0] d0;
      out_ready = (stall == 0);
      in_valid  = 1'b1;
      din       = 8'(x);
      tick();
      in_valid  = 1'b0;
      lat = 1;
      while (!out_valid && lat < 40) begin
         tick();
         lat++;
      end
      if (!out_valid) begin
         check("out_valid_timeout", out_valid, 1);
      end
      d0 = dout;
      for (int s = 0; s < stall; s++) begin
         if (poke) begin
            cfg_we   = 1'b1;
            cfg_addr = 3'd0;
            cfg_data = 8'd1;
         end
         check("stall_dout_stable", $signed(dout), $signed(d0));
         check("stall_in_ready", in_ready, 0);
         check("stall_cfg_busy", cfg_busy, 1);
         tick();
      end
      cfg_we    = 1'b0;
      out_ready = 1'b1;
      y = $signed(dout);
      tick();
      if (stall > 0) begin
         check("after_out_valid", out_valid, 0);
         check("after_dout_hold", $signed(dout), y);
      end
   endtask

   typedef struct {
      bit do_rst;
      int c [5];
      int x;
      int exp;
   } vec_t;

`ifdef IIR_SAT_EN
   localparam int OVF_EXP = 127;
`else
   localparam int OVF_EXP = -4;
`endif

   vec_t vecs [9];

   initial begin
      int y;
      int lat;
      int e;
      vecs[0] = '{1'b1, '{64, 0, 0, 0, 0},   5,  5};
      vecs[1] = '{1'b0, '{0, 0, 0, 0, 0},   -7, -7};
      vecs[2] = '{1'b1, '{32, 32, 0, 0, 0},  10, 5};
      vecs[3] = '{1'b0, '{0, 0, 0, 0, 0},    20, 15};
      vecs[4] = '{1'b1, '{64, 0, 0, 32, 0},  64, 64};
      vecs[5] = '{1'b0, '{0, 0, 0, 0, 0},    0,  32};
      vecs[6] = '{1'b0, '{0, 0, 0, 0, 0},    0,  16};
      vecs[7] = '{1'b0, '{0, 0, 0, 0, 0},    0,  8};
      vecs[8] = '{1'b1, '{127, 0, 0, 0, 0},  127, OVF_EXP};

      tick();
      check("in_reset_in_ready", in_ready, 0);
      check("in_reset_dout", $signed(dout), 0);

      // ---------------- directed table ----------------
      for (int i = 0; i < 9; i++) begin
         if (vecs[i].do_rst) begin
            do_reset();
            for (int a = 0; a < 5; a++) wcoef(a, vecs[i].c[a]);
         end
         e = model_step(vecs[i].x);
         run_sample(vecs[i].x, 0, 1'b0, y, lat);
         check($sformatf("vec%0d_dout", i), y, vecs[i].exp);
         if (i == 0) check("latency", lat, 6);
      end

      // ---------------- backpressure with cfg lockout ----------------
      do_reset();
      wcoef(0, 64);
      run_sample(9, 3, 1'b1, y, lat);
      check("bp_dout", y, 9);
      run_sample(-20, 0, 1'b0, y, lat);
      check("bp_b0_unchanged", y, -20);

      // ---------------- reset mid-MAC ----------------
      wcoef(1, 64);
      wcoef(3, 64);
      in_valid = 1'b1;
      din      = 8'd50;
      tick();
      in_valid = 1'b0;
      tick();
      rst = 1'b0;
      tick();
      check("midmac_in_ready", in_ready, 0);
      check("midmac_out_valid", out_valid, 0);
      rst = 1'b1;
      tick();
      check("midmac_rel_in_ready", in_ready, 1);
      check("midmac_rel_out_valid", out_valid, 0);
      model_reset();
      wcoef(0, 64);
      wcoef(1, 64);
      wcoef(3, 64);
      run_sample(-33, 0, 1'b0, y, lat);
      check("midmac_history_cleared", y, -33);

      // ---------------- randomized against model ----------------
      do_reset();
      for (int a = 0; a < 8; a++) wcoef(a, int'($urandom_range(0, 255)) - 128);
      for (int n = 0; n < 80; n++) begin
         int x;
         int st;
         if ($urandom_range(0, 3) == 0) begin
            wcoef(int'($urandom_range(0, 7)), int'($urandom_range(0, 255)) - 128);
         end
         x  = int'($urandom_range(0, 255)) - 128;
         st = int'($urandom_range(0, 2));
         e  = model_step(x);
         run_sample(x, st, 1'b1, y, lat);
         check($sformatf("rand%0d_dout", n), y, e);
         check($sformatf("rand%0d_latency", n), lat, 6);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/iir_mac_sequencer.md
Name: iir_mac_sequencer

Overview:
Time-multiplexed controller and datapath for a direct-form-I IIR filter: one shared 8x8 signed multiply-accumulate unit is sequenced over NB feedforward and NA feedback taps per sample.
- Sits between the sample source and the sample sink, each with a valid/ready handshake.
- Owns the coefficient bank, the x/y delay lines and the tap scheduling state machine.
- Replaces the fully parallel 5-register filter with a single-multiplier implementation.

Parameters:
NB, 3, number of feedforward taps b0..b(NB-1)
NA, 2, number of feedback taps a1..aNA
DW, 8, sample and coefficient width (signed)
FRAC, 6, coefficient fractional bits (Q1.6 at DW=8)
ACC_W, 20, accumulator width (must be >= 2*DW + clog2(NB+NA))

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-low
in_valid  in  1  input sample valid
in_ready  out  1  block can accept a sample
din  in  DW  signed input sample x[n]
out_valid  out  1  dout holds y[n]
out_ready  in  1  sink accepts dout
dout  out  DW  signed filter output y[n]
cfg_we  in  1  coefficient write strobe
cfg_addr  in  3  0..NB-1 selects b_k; NB..NB+NA-1 selects a_(addr-NB+1)
cfg_data  in  DW  signed coefficient, Q1.FRAC
cfg_busy  out  1  high when not in IDLE; writes are dropped

Behaviour:
- All state updates on the rising edge of clk. rst is sampled synchronously, and rst==0 overrides everything.
- Reset clears the following to 0: state=IDLE, tap counter, accumulator, all x/y delay registers and all coefficients.
- Output values during reset: in_ready=0, out_valid=0, dout=0, cfg_busy=0.
- FSM states are IDLE, MAC and OUT.
- IDLE:
  - in_ready=1.
  - cfg_we writes cfg_data to the coefficient at cfg_addr. Addresses >= NB+NA are ignored.
  - On in_valid&&in_ready: capture din as x0, clear acc, set tap=0, go to MAC.
  - A cfg write in the same cycle as the handshake is applied, and the new coefficient is used for this sample.
- MAC:
  - One tap per cycle: acc <= acc + sext(coef[tap]) * operand[tap].
  - operand[k] = x[n-k] for k<NB; operand[NB+j-1] = y[n-j] for j=1..NA.
  - tap increments. After tap==NB+NA-1 the FSM goes to OUT.
  - Feedback is additive. Software loads negated denominator coefficients.
- OUT:
  - out_valid=1, and dout = (acc >>> FRAC), arithmetic shift with truncation toward -inf, reduced to DW bits (see optional feature).
  - dout is stable while out_ready=0.
  - On out_ready: shift x line (x[n-k] <= x[n-k+1]), shift y line with y[n-1] <= dout, go to IDLE.
- Latency:
  - Handshake at cycle 0; out_valid is first high at cycle NB+NA+1 (6 at defaults).
  - Throughput is one sample per NB+NA+2 cycles with out_ready held high.
- in_ready=0 and cfg_busy=1 in MAC and OUT. cfg_we in those states is dropped with no side effects.
- out_valid is low outside OUT, and dout keeps its last value when out_valid is low.
- Reset mid-MAC or mid-OUT: the sample is discarded and the next cycle is IDLE with all state cleared. No partial output is emitted.
- The accumulator never overflows at ACC_W >= 19 for the defaults. No internal accumulator saturation.

Optional Feature:
Macro IIR_SAT_EN.
- Defined: the shifted accumulator is clamped to [-2^(DW-1), 2^(DW-1)-1] before it drives dout and enters the y delay line.
- Undefined: the low DW bits are taken (two's-complement wrap).

Decomposition:
- Shared package iir_pkg holds:
  - FSM state enum (IDLE/MAC/OUT)
  - default NB/NA/DW/FRAC/ACC_W constants
  - cfg address constants (B0_ADDR, A1_ADDR)
- One sub-module, iir_mac_unit: signed DW x DW multiply plus ACC_W accumulate with a clear input, and the output shift/saturate stage.
- The FSM, tap counter, coefficient bank and delay lines stay in the top.

Test Plan:
- Passthrough: b0=64, all other coefficients 0; din=5 -> out_valid 6 cycles after the handshake, dout=5; din=-7 -> dout=-7.
- Two-tap average: b0=b1=32; feed 10 then 20 -> dout 5 then 15.
- Feedback decay: b0=64, a1=32; feed 64,0,0,0 -> dout 64,32,16,8.
- Overflow: b0=127, din=127, so acc=16129 and >>>6 = 252.
  - With IIR_SAT_EN: dout=127.
  - Without: dout=-4.
- Backpressure and config lockout:
  - Hold out_ready=0 for 3 cycles in OUT -> dout stable, in_ready=0, cfg_busy=1.
  - A cfg_we to b0 during those cycles -> b0 unchanged on the next sample.
- Reset mid-MAC: drop rst to 0 at cycle 2 after the handshake -> next cycle in_ready=0 and out_valid=0.
  - After release: in_ready=1, and a new sample with b0=64 reloaded gives dout=din (history cleared).
